gf_mult_seq_ctrl: RTL and testbench
===================================

// Module: gf_mult_seq_ctrl
// PURPOSE
//   Iterative GF(2^m) multiplier controller: accepts operands on a valid/ready handshake.
//   Sequences a DIGIT-bit-per-cycle carry-less shift-and-XOR multiply, then optionally a
//   modular reduction by a programmable polynomial. Area-lean alternative to the
//   fully-combinational carry-less array; a drop-in for multiplier comparisons.
// PARAMETERS
//   DATA_WIDTH  32  operand width N (field GF(2^N)); >=2
//   DIGIT       1   bits of b consumed per cycle; must divide DATA_WIDTH
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       operand request
//   in_ready   out  1       controller can accept (high only in IDLE)
//   a          in   N       multiplicand
//   b          in   N       multiplier
//   poly       in   N       reduction polynomial low bits; x^N term implicit
//   reduce     in   1       1: out = a*b mod P; 0: out = full carry-less product
//   out_valid  out  1       result valid (high only in DONE)
//   out_ready  in   1       consumer accepts result
//   out        out  2N      result; when reduce=1, out[2N-1:N] = 0
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; acc, counters and latched operands cleared.
//   Outputs at reset: in_ready=1, out_valid=0, out=0, busy=0. Reset mid-operation aborts
//   silently; no result is produced.
//   States IDLE -> MULT -> [RED] -> DONE -> IDLE.
//   - IDLE: in_ready=1. in_valid & in_ready latches a, b, poly, reduce; clears acc; ->MULT.
//   - MULT: N/DIGIT cycles. Cycle k processes bits b[k*D +: D], LSB first:
//     acc ^= a << j for each set bit j. Counter reaches N/D-1 -> RED if reduce, else DONE.
//   - RED: N/DIGIT cycles. Scans acc bits 2N-1 down to N, D bits per cycle, MSB first.
//     Bits within a cycle are chained combinationally. Set bit k: acc ^= {1,poly} << (k-N).
//     Last cycle -> DONE. Bit 2N-1 is always 0 but is still scanned (fixed latency).
//   - DONE: out_valid=1, out=acc held stable until out_valid & out_ready -> IDLE.
//     in_ready rises the cycle after the handoff; there is no same-cycle bypass.
//   Latency: out_valid asserts after N/D clock edges past the accepting edge (reduce=0),
//   or 2N/D edges (reduce=1). Throughput is one operation per latency+2 cycles minimum.
//   a, b, poly and reduce are ignored outside the IDLE accept; changes while busy have no effect.
//   in_valid while busy is not dropped: it waits with in_ready=0 (requester holds).
//   out holds its last value when not in DONE; only out_valid qualifies it.
//   Zero operands: full latency still applies; result = 0.
//   Arithmetic is pure XOR (no carries); acc is 2N bits wide; no overflow is possible.
// TESTING  (N=8, DIGIT=1 unless noted)
//   1. Reset low mid-MULT with a=0x57, b=0x83 -> next cycle in_ready=1, out_valid=0,
//      busy=0; no result emitted.
//   2. a=0x57, b=0x83, reduce=0 -> out_valid after 8 edges; out=0x2B79.
//   3. a=0x57, b=0x83, poly=0x1B, reduce=1 -> out_valid after 16 edges; out=0x00C1.
//      Also a=0x80, b=0x02 -> 0x001B.
//   4. Backpressure: out_ready=0 for 5 cycles -> out stable, in_ready=0. Change a/b/in_valid
//      while busy -> no effect. out_ready=1 -> IDLE next edge.
//   5. Back-to-back: 0x57*0x13 then 0x57*0x02, reduce=1, in_valid held high ->
//      results 0x00FE then 0x00AE, in order.
//   6. N=32, DIGIT=4: 500 random a/b/reduce with poly=0x0000008D, against a bitwise model
//      -> all match; latency 8 / 16 edges.

Source files
------------

// File: rtl/gf_mult_seq_ctrl.sv
// Iterative GF(2^N) multiplier: DIGIT-bit-per-cycle carry-less multiply, then an optional
// DIGIT-bit-per-cycle modular reduction by a programmable polynomial with implicit x^N term.
module gf_mult_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DIGIT      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic [DATA_WIDTH-1:0]     poly,
  input  logic                      reduce,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out,
  output logic                      busy
);

  localparam int N     = DATA_WIDTH;
  localparam int STEPS = N / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] RED  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_mult;
  logic [2*N-1:0] acc_red;
  logic [2*N-1:0] out_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   poly_q;
  logic           reduce_q;
  logic           last;

  // Digit idx of b selects bit positions idx*DIGIT .. idx*DIGIT+DIGIT-1 (LSB first).
  function automatic logic [2*N-1:0] mult_step(input logic [2*N-1:0] acc_i,
                                               input logic [N-1:0] a_i,
                                               input logic [N-1:0] b_i,
                                               input logic [CW-1:0] idx);
    logic [2*N-1:0] r;
    logic [2*N-1:0] a_ext;
    logic [N-1:0]   b_sh;
    int             base;
    r     = acc_i;
    a_ext = {{N{1'b0}}, a_i};
    base  = int'(idx) * DIGIT;
    for (int j = 0; j < DIGIT; j++) begin
      b_sh = b_i >> (base + j);
      if (b_sh[0]) r = r ^ (a_ext << (base + j));
    end
    return r;
  endfunction

  // Scans DIGIT high bits MSB first; each cancellation feeds the next bit test in the same cycle.
  function automatic logic [2*N-1:0] red_step(input logic [2*N-1:0] acc_i,
                                              input logic [N-1:0] poly_i,
                                              input logic [CW-1:0] idx);
    logic [2*N-1:0] r;
    logic [2*N-1:0] p_ext;
    logic [2*N-1:0] t;
    int             k;
    r     = acc_i;
    p_ext = {{(N-1){1'b0}}, 1'b1, poly_i};
    for (int i = 0; i < DIGIT; i++) begin
      k = 2*N - 1 - int'(idx) * DIGIT - i;
      t = r >> k;
      if (t[0]) r = r ^ (p_ext << (k - N));
    end
    return r;
  endfunction

  always_comb begin
    acc_mult = mult_step(acc, a_q, b_q, cnt);
    acc_red  = red_step(acc, poly_q, cnt);
    last     = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      out_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      poly_q   <= '0;
      reduce_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            poly_q   <= poly;
            reduce_q <= reduce;
            acc      <= '0;
            cnt      <= '0;
            state    <= MULT;
          end
        end
        MULT: begin
          acc <= acc_mult;
          if (last) begin
            cnt <= '0;
            if (reduce_q) begin
              state <= RED;
            end else begin
              out_q <= acc_mult;
              state <= DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RED: begin
          acc <= acc_red;
          if (last) begin
            cnt   <= '0;
            out_q <= acc_red;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = out_q;

endmodule

// File: tb/tb_gf_mult_seq_ctrl.sv
// Scoreboard bench: directed N=8 vectors plus randomized N=32/DIGIT=4 operations.
module tb_gf_mult_seq_ctrl;

  typedef struct packed {
    logic [63:0] val;
    logic [63:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid8, in_ready8, red8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8, poly8;
  logic [15:0] out8;

  logic        in_valid32, in_ready32, red32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32, poly32;
  logic [63:0] out32;

  exp_t q8[$];
  exp_t q32[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc8 = 0;
  int acc_cyc32 = 0;
  bit first8 = 1'b1;
  bit first32 = 1'b1;
  bit pend_idle8 = 1'b0;
  logic [15:0] held8;

  gf_mult_seq_ctrl #(.DATA_WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .poly(poly8), .reduce(red8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out(out8), .busy(busy8)
  );

  gf_mult_seq_ctrl #(.DATA_WIDTH(32), .DIGIT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .poly(poly32), .reduce(red32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out(out32), .busy(busy32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] p, input logic r);
    logic [63:0] prod;
    logic [31:0] aa, res, yy;
    logic        c;
    prod = '0;
    res  = '0;
    aa   = x;
    yy   = y;
    for (int i = 0; i < 32; i++) begin
      if (r) begin
        if (yy[0]) res = res ^ aa;
        c  = aa[31];
        aa = {aa[30:0], 1'b0};
        if (c) aa = aa ^ p;
      end else if (yy[0]) begin
        prod = prod ^ ({32'h0, x} << i);
      end
      yy = yy >> 1;
    end
    if (r) prod = {32'h0, res};
    return prod;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 64'(in_ready8), 64'(1));
        chk("rst_out_valid", 64'(out_valid8), 64'(0));
        chk("rst_busy", 64'(busy8), 64'(0));
        chk("rst_out", 64'(out8), 64'(0));
        first8 = 1'b1;
        first32 = 1'b1;
        pend_idle8 = 1'b0;
      end else begin
        if (pend_idle8) begin
          chk("idle_after_handoff", 64'(in_ready8), 64'(1));
          pend_idle8 = 1'b0;
        end
        if (in_valid8 && in_ready8) acc_cyc8 = cyc + 1;
        if (in_valid32 && in_ready32) acc_cyc32 = cyc + 1;
        if (out_valid8) begin
          chk("in_ready_in_done", 64'(in_ready8), 64'(0));
          chk("busy_in_done", 64'(busy8), 64'(1));
          if (first8) begin
            if (q8.size() == 0) begin
              chk("unexpected_result8", 64'(out_valid8), 64'(0));
            end else begin
              chk("latency8", 64'(cyc - acc_cyc8), q8[0].lat);
              chk("result8", 64'(out8), q8[0].val);
            end
            held8 = out8;
            first8 = 1'b0;
          end else begin
            chk("out_stable8", 64'(out8), 64'(held8));
          end
          if (out_ready8) begin
            if (q8.size() != 0) void'(q8.pop_front());
            first8 = 1'b1;
            pend_idle8 = 1'b1;
          end
        end
        if (out_valid32) begin
          if (first32) begin
            if (q32.size() == 0) begin
              chk("unexpected_result32", 64'(out_valid32), 64'(0));
            end else begin
              chk("latency32", 64'(cyc - acc_cyc32), q32[0].lat);
              chk("result32", out32, q32[0].val);
            end
            first32 = 1'b0;
          end
          if (out_ready32) begin
            if (q32.size() != 0) void'(q32.pop_front());
            first32 = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ip,
                        input logic ir, input logic [15:0] ev, input int lat,
                        input bit hold, input bit push);
    int n;
    a8 = ia; b8 = ib; poly8 = ip; red8 = ir; in_valid8 = 1'b1;
    if (push) q8.push_back('{val: 64'(ev), lat: 64'(lat)});
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready8) break;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout8: in_ready stayed 0 for %0d cycles", n);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    if (!hold) in_valid8 = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] ia, input logic [31:0] ib, input logic ir);
    int n;
    a32 = ia; b32 = ib; red32 = ir; in_valid32 = 1'b1;
    q32.push_back('{val: model32(ia, ib, poly32, ir), lat: (ir ? 64'd16 : 64'd8)});
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready32) break;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout32: in_ready stayed 0 for %0d cycles", n);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q8.size() != 0 || q32.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 1000) begin
        $display("FAIL drain_timeout: %0d/%0d results outstanding", q8.size(), q32.size());
        $fatal(1);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    in_valid8 = 0; a8 = 0; b8 = 0; poly8 = 0; red8 = 0; out_ready8 = 1;
    in_valid32 = 0; a32 = 0; b32 = 0; poly32 = 32'h0000008D; red32 = 0; out_ready32 = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of MULT: no result may appear afterwards.
    issue8(8'h57, 8'h83, 8'h00, 1'b0, 16'h0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Directed products, unreduced and reduced, including zero operands.
    issue8(8'h57, 8'h83, 8'h00, 1'b0, 16'h2B79, 8, 1'b0, 1'b1);
    issue8(8'h57, 8'h83, 8'h1B, 1'b1, 16'h00C1, 16, 1'b0, 1'b1);
    issue8(8'h80, 8'h02, 8'h1B, 1'b1, 16'h001B, 16, 1'b0, 1'b1);
    issue8(8'h00, 8'h5A, 8'h1B, 1'b0, 16'h0000, 8, 1'b0, 1'b1);
    issue8(8'hFF, 8'hFF, 8'h1B, 1'b0, 16'h5555, 8, 1'b0, 1'b1);
    issue8(8'h01, 8'h80, 8'h1B, 1'b1, 16'h0080, 16, 1'b0, 1'b1);
    issue8(8'h00, 8'h00, 8'h1B, 1'b1, 16'h0000, 16, 1'b0, 1'b1);
    drain();

    // Backpressure with operand churn while busy.
    out_ready8 = 1'b0;
    issue8(8'h57, 8'h83, 8'h1B, 1'b1, 16'h00C1, 16, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 a8 = 8'hFF; b8 = 8'hFF; poly8 = 8'h00; red8 = 1'b0; in_valid8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        $display("FAIL out_valid_timeout8: out_valid stayed 0 for %0d cycles", n);
        $fatal(1);
      end
    end
    repeat (5) @(posedge clk);
    #1 out_ready8 = 1'b1;
    drain();

    // Back-to-back with in_valid held across the first accept.
    issue8(8'h57, 8'h13, 8'h1B, 1'b1, 16'h00FE, 16, 1'b1, 1'b1);
    issue8(8'h57, 8'h02, 8'h1B, 1'b1, 16'h00AE, 16, 1'b0, 1'b1);
    drain();

    // Wide instance, DIGIT=4, random operands.
    for (int i = 0; i < 500; i++) begin
      issue32($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
